rf_wr_arb: RTL

Arbiter for the single register-file write port. It shares the port between the pipeline write-back stage (W) and a secondary requester (multi-cycle unit results, e.g. multiply/divide or late load fill). Secondary writes are queued in a small FIFO, and W has priority with bounded starvation of the queue. The block also tracks pending destinations so the hazard unit can stall readers of registers with queued writes.

---
 rtl/rf_wr_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: W stage has priority, secondary writes queue in a FIFO
// with bounded starvation; queued destinations are exported for hazard detection.
module rf_wr_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_we,
  input  logic [4:0]    w_wa,
  input  logic [31:0]   w_wd,
  output logic          w_stall,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_wa,
  input  logic [31:0]   s_wd,
  output logic          rf_we,
  output logic [4:0]    rf_wa,
  output logic [31:0]   rf_wd,
  output logic [31:0]   busy_mask,
  output logic [CW-1:0] pend_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]    rd_ptr, wr_ptr, occ;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic [DEPTH-1:0] ent_vld, vld_nxt;
  logic [4:0]       ent_wa [DEPTH];
  logic [31:0]      ent_wd [DEPTH];
  logic [WW-1:0]    wait_cnt;

  logic w_req, s_req, head_used, starve;
  logic grant_w, grant_s, pop, push, push_keep;

  assign occ    = wr_ptr - rd_ptr;
  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];

  // Occupancy counts invalidated slots too; they drain through the head.
  assign s_ready   = (occ != CW'(DEPTH));
  assign head_used = (occ != '0);
  assign s_req     = head_used && ent_vld[rd_idx];
  assign w_req     = w_we && (w_wa != 5'd0);
  assign starve    = s_req && (wait_cnt >= WW'(STARVE_MAX));

  assign grant_s = s_req && (starve || !w_req);
  assign grant_w = w_req && !starve;
  assign w_stall = starve && w_req;

  assign pop       = head_used && (!ent_vld[rd_idx] || grant_s);
  assign push      = s_valid && s_ready;
  // A same-cycle W grant to the same register is the newer write.
  assign push_keep = (s_wa != 5'd0) && !(grant_w && (w_wa == s_wa));

  always_comb begin
    vld_nxt = ent_vld;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_w && (ent_wa[i] == w_wa)) vld_nxt[i] = 1'b0;
      if (pop && (AW'(i) == rd_idx))      vld_nxt[i] = 1'b0;
      if (push && (AW'(i) == wr_idx))     vld_nxt[i] = push_keep;
    end
  end

  always_comb begin
    busy_mask  = '0;
    pend_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        busy_mask[ent_wa[i]] = 1'b1;
        pend_count           = pend_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wa[i] <= '0;
        ent_wd[i] <= '0;
      end
    end else begin
      ent_vld <= vld_nxt;
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      if (push) begin
        wr_ptr         <= wr_ptr + CW'(1);
        ent_wa[wr_idx] <= s_wa;
        ent_wd[wr_idx] <= s_wd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!s_req || grant_s) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WW'(STARVE_MAX)) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= grant_s || grant_w;
      if (grant_s) begin
        rf_wa <= ent_wa[rd_idx];
        rf_wd <= ent_wd[rd_idx];
      end else if (grant_w) begin
        rf_wa <= w_wa;
        rf_wd <= w_wd;
      end
    end
  end

endmodule
